echo_delay_ctrl: RTL



---
 rtl/echo_delay_ctrl_pkg.sv | 16 +
 rtl/echo_delay_ctrl_if.sv | 28 ++
 rtl/echo_delay_ctrl_sample_strobe.sv | 29 ++
 rtl/echo_delay_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/echo_delay_ctrl_pkg.sv
// Shared definitions for the echo delay FIFO controller.
// State encoding, default FIFO address width and the minimum usable delay.
package echo_pkg;

  localparam int DEPTH_W_DEF = 10;
  localparam int MIN_DELAY   = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/echo_delay_ctrl_if.sv
// FIFO-side bundle of the echo delay controller: request/clear strobes,
// the full flag coming back from the FIFO, and the echo-valid qualifier
// that travels with the FIFO q towards the mixer.
interface echo_delay_ctrl_if;

  logic fifo_wrreq;
  logic fifo_rdreq;
  logic fifo_sclr;
  logic fifo_full;
  logic echo_valid;

  modport master (
    output fifo_wrreq,
    output fifo_rdreq,
    output fifo_sclr,
    output echo_valid,
    input  fifo_full
  );

  modport slave (
    input  fifo_wrreq,
    input  fifo_rdreq,
    input  fifo_sclr,
    input  echo_valid,
    output fifo_full
  );

endinterface

// File: rtl/echo_delay_ctrl_sample_strobe.sv
// Brings the asynchronous ADC data_valid level into sysclk and turns each
// rising edge into a single registered pulse, three sysclk edges after the rise.
module sample_strobe (
  input  logic sysclk,
  input  logic rst,
  input  logic data_valid,
  output logic sample_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Two-flop synchronizer followed by a registered rising-edge detector
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_1       <= 1'b0;
      sync_2       <= 1'b0;
      sync_prev    <= 1'b0;
      sample_pulse <= 1'b0;
    end else begin
      sync_1       <= data_valid;
      sync_2       <= sync_1;
      sync_prev    <= sync_2;
      sample_pulse <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/echo_delay_ctrl.sv
// Delay FIFO sequencer for the audio echo path. Keeps the FIFO occupancy
// equal to the requested delay, qualifies the FIFO output for the mixer and
// handles delay changes, flushes and disable.
// Optional build macro ECHO_DRAIN_EN: when defined, a shorter delay is
// reached by draining surplus words (echo stays audible); when undefined the
// DRAIN state is absent and a shorter delay flushes and refills the FIFO.
//
// state | meaning
// IDLE  | echo bypassed, no FIFO traffic
// FILL  | writing samples only until occupancy reaches the delay
// RUN   | one write and one read per sample, echo valid
// DRAIN | reading one surplus word per cycle down to the new delay
// FLUSH | one-cycle FIFO clear, then FILL (enabled) or IDLE
module echo_delay_ctrl
  import echo_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               data_valid,
  input  logic               echo_en,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] delay_len,
  echo_delay_ctrl_if.master  fifo_if,
  output logic               sample_pulse,
  output logic               overflow,
  output logic [2:0]         state
);

  localparam logic [DEPTH_W:0] CNT_ONE = {{DEPTH_W{1'b0}}, 1'b1};

  state_t             state_q;
  state_t             shrink_state;
  logic [DEPTH_W:0]   fill_cnt;
  logic [DEPTH_W:0]   fill_inc;
  logic [DEPTH_W:0]   fill_dec;
  logic [DEPTH_W-1:0] delay_q;
  logic [DEPTH_W-1:0] delay_in;
  logic [DEPTH_W:0]   delay_x;
  logic               active;
  logic               abort;

  sample_strobe u_strobe (
    .sysclk       (sysclk),
    .rst          (rst),
    .data_valid   (data_valid),
    .sample_pulse (sample_pulse)
  );

  assign state    = state_q;
  assign fill_inc = fill_cnt + CNT_ONE;
  assign fill_dec = fill_cnt - CNT_ONE;
  // A requested delay of zero would never let the FIFO produce an echo.
  assign delay_in = (delay_len == '0) ? DEPTH_W'(MIN_DELAY) : delay_len;
  // The delay being latched on this sample is the one the decisions use.
  assign delay_x  = {1'b0, (sample_pulse ? delay_in : delay_q)};

`ifdef ECHO_DRAIN_EN
  assign shrink_state = DRAIN;
  assign active = (state_q == FILL) || (state_q == RUN) || (state_q == DRAIN);
`else
  assign shrink_state = FLUSH;
  assign active = (state_q == FILL) || (state_q == RUN);
`endif

  assign abort = (state_q != IDLE) && (state_q != FLUSH) && (flush || !echo_en);

  // Sequencer: state, occupancy count, delay latch and registered FIFO controls
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      fill_cnt           <= '0;
      delay_q            <= DEPTH_W'(MIN_DELAY);
      overflow           <= 1'b0;
      fifo_if.fifo_wrreq <= 1'b0;
      fifo_if.fifo_rdreq <= 1'b0;
      fifo_if.fifo_sclr  <= 1'b0;
      fifo_if.echo_valid <= 1'b0;
    end else begin
      fifo_if.fifo_wrreq <= 1'b0;
      fifo_if.fifo_rdreq <= 1'b0;
      fifo_if.fifo_sclr  <= 1'b0;
      if (sample_pulse) delay_q <= delay_in;

      if (abort) begin
        // flush/disable beats a coincident sample: nothing written or read
        state_q            <= FLUSH;
        fifo_if.echo_valid <= 1'b0;
      end else if (active && sample_pulse) begin
        if (fill_cnt < delay_x) begin
          // Growing: write only; a full FIFO drops the sample and holds state
          if (fifo_if.fifo_full) begin
            overflow <= 1'b1;
          end else begin
            fifo_if.fifo_wrreq <= 1'b1;
            fifo_if.echo_valid <= 1'b0;
            fill_cnt           <= fill_inc;
            state_q            <= (fill_inc == delay_x) ? RUN : FILL;
          end
        end else begin
          // Paired write+read keeps the occupancy and is never suppressed
          fifo_if.fifo_wrreq <= 1'b1;
          fifo_if.fifo_rdreq <= 1'b1;
          fifo_if.echo_valid <= 1'b1;
          state_q            <= (fill_cnt == delay_x) ? RUN : shrink_state;
        end
      end else begin
        case (state_q)
          IDLE: begin
            fifo_if.echo_valid <= 1'b0;
            if (echo_en) state_q <= FLUSH;
          end
          FLUSH: begin
            fifo_if.fifo_sclr  <= 1'b1;
            fifo_if.echo_valid <= 1'b0;
            fill_cnt           <= '0;
            overflow           <= 1'b0;
            state_q            <= echo_en ? FILL : IDLE;
          end
`ifdef ECHO_DRAIN_EN
          DRAIN: begin
            if (fill_cnt > delay_x) begin
              fifo_if.fifo_rdreq <= 1'b1;
              fill_cnt           <= fill_dec;
              if (fill_dec == delay_x) state_q <= RUN;
            end else begin
              state_q <= RUN;
            end
          end
`endif
          FILL, RUN: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
